// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: consumer-side safety checker for the intersection light bus.
// Optional SHORT_GREEN check (code 6) enabled by defining MONITOR_MIN_GREEN_EN.
module traffic_light_monitor #(
    parameter int unsigned TIMER_W      = 16,
    parameter int unsigned MIN_YELLOW   = 1000,
    parameter int unsigned MIN_GREEN    = 5000,
    parameter int unsigned FLASH_PERIOD = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] main_light,
    input  logic [2:0] side_light,
    input  logic       pedestrian_signal,
    input  logic       clear_fault,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_road,
    output logic       failsafe_flash,
    output logic [7:0] fault_count
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int unsigned FCNT_W =
        (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
    localparam logic [FCNT_W-1:0] FLASH_LAST = FCNT_W'(FLASH_PERIOD - 1);
    localparam logic [TIMER_W-1:0] HOLD_ONE = TIMER_W'(1);

    typedef enum logic {S_MONITOR, S_FAULT} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_prev_main;
    logic [2:0]          r_prev_side;
    logic [TIMER_W-1:0]  r_hold_main;
    logic [TIMER_W-1:0]  r_hold_side;
    logic [2:0]          r_fault_code;
    logic [1:0]          r_fault_road;
    logic                r_flash;
    logic [FCNT_W-1:0]   r_flash_cnt;
    logic [7:0]          r_fault_count;

    logic [1:0] w_enc;
    logic       w_conflict;
    logic [1:0] w_seq;
    logic [1:0] w_short_y;
    logic [1:0] w_short_g;
    logic       w_ped;
    logic [1:0] w_per_road;
    logic [2:0] w_code;
    logic [1:0] w_road;
    logic       w_clear_ok;
    logic       w_enter;
    logic       w_exit;

    function automatic logic valid_enc(input logic [2:0] l);
        return (l == RED) || (l == YEL) || (l == GRN);
    endfunction

    function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
        return (p == c) || (p == GRN && c == YEL) ||
               (p == YEL && c == RED) || (p == RED && c == GRN);
    endfunction

    assign w_enc[0]   = !valid_enc(main_light);
    assign w_enc[1]   = !valid_enc(side_light);
    assign w_conflict = (main_light != RED) && (side_light != RED);
    assign w_seq[0]   = !legal_step(r_prev_main, main_light);
    assign w_seq[1]   = !legal_step(r_prev_side, side_light);

    // Yellow length is judged on the count of yellow samples held so far
    assign w_short_y[0] = (r_prev_main == YEL) && (main_light == RED) &&
                          (32'(r_hold_main) < MIN_YELLOW);
    assign w_short_y[1] = (r_prev_side == YEL) && (side_light == RED) &&
                          (32'(r_hold_side) < MIN_YELLOW);

`ifdef MONITOR_MIN_GREEN_EN
    assign w_short_g[0] = (r_prev_main == GRN) && (main_light == YEL) &&
                          (32'(r_hold_main) < MIN_GREEN);
    assign w_short_g[1] = (r_prev_side == GRN) && (side_light == YEL) &&
                          (32'(r_hold_side) < MIN_GREEN);
`else
    // Code 6 is never raised; this expression folds to constant zero
    assign w_short_g = {2{1'b0 && (MIN_GREEN != 0)}};
`endif

    assign w_ped = pedestrian_signal &&
                   ((main_light != RED) || (side_light != RED));

    // Per-road codes report every road that broke any per-road rule
    assign w_per_road = w_enc | w_seq | w_short_y | w_short_g;

    // Priority encode the active checks, lowest code wins
    always_comb begin
        w_code = 3'd0;
        w_road = 2'b00;
        if (|w_enc) begin
            w_code = 3'd1;
            w_road = w_per_road;
        end else if (w_conflict) begin
            w_code = 3'd2;
            w_road = 2'b11;
        end else if (|w_seq) begin
            w_code = 3'd3;
            w_road = w_per_road;
        end else if (|w_short_y) begin
            w_code = 3'd4;
            w_road = w_per_road;
        end else if (w_ped) begin
            w_code = 3'd5;
            w_road = 2'b11;
        end else if (|w_short_g) begin
            w_code = 3'd6;
            w_road = w_per_road;
        end
    end

    assign w_clear_ok = clear_fault && (main_light == RED) &&
                        (side_light == RED) && !pedestrian_signal;

    // Next-state and transition strobes
    always_comb begin
        w_state_next = r_state;
        w_enter      = 1'b0;
        w_exit       = 1'b0;
        case (r_state)
            S_MONITOR: begin
                if (w_code != 3'd0) begin
                    w_state_next = S_FAULT;
                    w_enter      = 1'b1;
                end
            end
            S_FAULT: begin
                if (w_clear_ok) begin
                    w_state_next = S_MONITOR;
                    w_exit       = 1'b1;
                end
            end
            default: w_state_next = S_MONITOR;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_MONITOR;
        else       r_state <= w_state_next;
    end

    // Previous samples and saturating hold counters, running in every state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_main <= RED;
            r_prev_side <= RED;
            r_hold_main <= '0;
            r_hold_side <= '0;
        end else begin
            r_prev_main <= main_light;
            r_prev_side <= side_light;
            if (w_exit) begin
                r_hold_main <= HOLD_ONE;
                r_hold_side <= HOLD_ONE;
            end else begin
                if (main_light != r_prev_main) r_hold_main <= HOLD_ONE;
                else if (!(&r_hold_main))      r_hold_main <= r_hold_main + 1'b1;
                if (side_light != r_prev_side) r_hold_side <= HOLD_ONE;
                else if (!(&r_hold_side))      r_hold_side <= r_hold_side + 1'b1;
            end
        end
    end

    // Latched fault record, entry counter and failsafe flasher
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault_code  <= 3'd0;
            r_fault_road  <= 2'b00;
            r_flash       <= 1'b0;
            r_flash_cnt   <= '0;
            r_fault_count <= 8'd0;
        end else if (w_enter) begin
            r_fault_code  <= w_code;
            r_fault_road  <= w_road;
            r_flash       <= 1'b1;
            r_flash_cnt   <= '0;
            if (r_fault_count != 8'hFF) r_fault_count <= r_fault_count + 8'd1;
        end else if (w_exit) begin
            r_fault_code <= 3'd0;
            r_fault_road <= 2'b00;
            r_flash      <= 1'b0;
            r_flash_cnt  <= '0;
        end else if (r_state == S_FAULT) begin
            if (r_flash_cnt == FLASH_LAST) begin
                r_flash_cnt <= '0;
                r_flash     <= !r_flash;
            end else begin
                r_flash_cnt <= r_flash_cnt + 1'b1;
            end
        end
    end

    assign fault          = (r_state == S_FAULT);
    assign fault_code     = r_fault_code;
    assign fault_road     = r_fault_road;
    assign failsafe_flash = r_flash;
    assign fault_count    = r_fault_count;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed self-checking bench for traffic_light_monitor.
// Uses MIN_YELLOW=4, FLASH_PERIOD=2, TIMER_W=8.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       pedestrian_signal;
    logic       clear_fault;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_road;
    logic       failsafe_flash;
    logic [7:0] fault_count;

    int checks = 0;
    int errors = 0;

    traffic_light_monitor #(
        .TIMER_W(8),
        .MIN_YELLOW(4),
        .MIN_GREEN(5000),
        .FLASH_PERIOD(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .main_light(main_light),
        .side_light(side_light),
        .pedestrian_signal(pedestrian_signal),
        .clear_fault(clear_fault),
        .fault(fault),
        .fault_code(fault_code),
        .fault_road(fault_road),
        .failsafe_flash(failsafe_flash),
        .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [2:0] m, input logic [2:0] s,
                        input logic p, input logic c);
        main_light        = m;
        side_light        = s;
        pedestrian_signal = p;
        clear_fault       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(R, R, 1'b0, 1'b0);
        reset = 1'b0;
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL reset_fault got %0b exp 0", fault);
        end
        checks++;
        if (fault_code !== 3'd0) begin
            errors++; $display("FAIL reset_code got %0d exp 0", fault_code);
        end
        checks++;
        if (fault_road !== 2'b00) begin
            errors++; $display("FAIL reset_road got %b exp 00", fault_road);
        end
        checks++;
        if (failsafe_flash !== 1'b0) begin
            errors++; $display("FAIL reset_flash got %0b exp 0", failsafe_flash);
        end
        checks++;
        if (fault_count !== 8'd0) begin
            errors++; $display("FAIL reset_count got %0d exp 0", fault_count);
        end
    endtask

    task automatic test_legal_cycle;
        logic [2:0] pm [6];
        logic [2:0] ps [6];
        int         pn [6];
        pm = '{G, Y, R, R, R, R};
        ps = '{R, R, R, G, Y, R};
        pn = '{10, 4, 1, 10, 4, 1};
        for (int it = 0; it < 3; it++) begin
            for (int ph = 0; ph < 6; ph++) begin
                for (int k = 0; k < pn[ph]; k++) begin
                    step(pm[ph], ps[ph], 1'b0, 1'b0);
                    checks++;
                    if (fault !== 1'b0) begin
                        errors++;
                        $display("FAIL legal_fault it=%0d ph=%0d got %0b exp 0",
                                 it, ph, fault);
                    end
                end
            end
        end
        checks++;
        if (fault_count !== 8'd0) begin
            errors++; $display("FAIL legal_count got %0d exp 0", fault_count);
        end
    endtask

    task automatic test_conflict;
        logic exp_flash [5];
        exp_flash = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        step(G, R, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL conflict_pre got %0b exp 0", fault);
        end
        step(G, G, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL conflict_fault got %0b exp 1", fault);
        end
        checks++;
        if (fault_code !== 3'd2) begin
            errors++; $display("FAIL conflict_code got %0d exp 2", fault_code);
        end
        checks++;
        if (fault_road !== 2'b11) begin
            errors++; $display("FAIL conflict_road got %b exp 11", fault_road);
        end
        checks++;
        if (fault_count !== 8'd1) begin
            errors++; $display("FAIL conflict_count got %0d exp 1", fault_count);
        end
        checks++;
        if (failsafe_flash !== 1'b1) begin
            errors++; $display("FAIL conflict_flash0 got %0b exp 1", failsafe_flash);
        end
        for (int i = 0; i < 5; i++) begin
            step(G, G, 1'b0, 1'b0);
            checks++;
            if (failsafe_flash !== exp_flash[i]) begin
                errors++;
                $display("FAIL conflict_flash%0d got %0b exp %0b",
                         i + 1, failsafe_flash, exp_flash[i]);
            end
        end
        step(R, R, 1'b0, 1'b1);
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL conflict_clear got %0b exp 0", fault);
        end
    endtask

    task automatic test_short_yellow;
        for (int i = 0; i < 5; i++) step(G, R, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(Y, R, 1'b0, 1'b0);
        step(R, R, 1'b0, 1'b0);
        checks++;
        if (fault_code !== 3'd4) begin
            errors++; $display("FAIL shorty_code got %0d exp 4", fault_code);
        end
        checks++;
        if (fault_road !== 2'b01) begin
            errors++; $display("FAIL shorty_road got %b exp 01", fault_road);
        end
        checks++;
        if (fault_count !== 8'd2) begin
            errors++; $display("FAIL shorty_count got %0d exp 2", fault_count);
        end
        step(R, R, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(G, R, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(Y, R, 1'b0, 1'b0);
        step(R, R, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL yellow4_fault got %0b exp 0", fault);
        end
    endtask

    task automatic test_priority;
        step(G, R, 1'b0, 1'b0);
        step(G, R, 1'b0, 1'b0);
        step(R, 3'b110, 1'b0, 1'b0);
        checks++;
        if (fault_code !== 3'd1) begin
            errors++; $display("FAIL prio_code got %0d exp 1", fault_code);
        end
        checks++;
        if (fault_road !== 2'b11) begin
            errors++; $display("FAIL prio_road got %b exp 11", fault_road);
        end
        checks++;
        if (fault_count !== 8'd3) begin
            errors++; $display("FAIL prio_count got %0d exp 3", fault_count);
        end
        step(R, R, 1'b0, 1'b1);
        step(3'b000, R, 1'b0, 1'b0);
        checks++;
        if (fault_code !== 3'd1) begin
            errors++; $display("FAIL enc0_code got %0d exp 1", fault_code);
        end
        checks++;
        if (fault_road !== 2'b01) begin
            errors++; $display("FAIL enc0_road got %b exp 01", fault_road);
        end
        step(R, R, 1'b0, 1'b1);
        step(G, R, 1'b1, 1'b0);
        checks++;
        if (fault_code !== 3'd5) begin
            errors++; $display("FAIL ped_code got %0d exp 5", fault_code);
        end
        checks++;
        if (fault_road !== 2'b11) begin
            errors++; $display("FAIL ped_road got %b exp 11", fault_road);
        end
        checks++;
        if (fault_count !== 8'd5) begin
            errors++; $display("FAIL ped_count got %0d exp 5", fault_count);
        end
        step(R, R, 1'b0, 1'b1);
    endtask

    task automatic test_clear_gating;
        step(G, R, 1'b0, 1'b0);
        step(G, G, 1'b0, 1'b0);
        step(G, R, 1'b0, 1'b1);
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL gate_green got %0b exp 1", fault);
        end
        step(R, R, 1'b1, 1'b1);
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL gate_ped got %0b exp 1", fault);
        end
        checks++;
        if (fault_code !== 3'd2) begin
            errors++; $display("FAIL gate_code got %0d exp 2", fault_code);
        end
        step(R, R, 1'b0, 1'b1);
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL gate_clear got %0b exp 0", fault);
        end
        checks++;
        if ({fault_code, fault_road, failsafe_flash} !== 6'd0) begin
            errors++;
            $display("FAIL gate_outs got code=%0d road=%b flash=%0b exp 0",
                     fault_code, fault_road, failsafe_flash);
        end
        step(G, R, 1'b0, 1'b1);
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL gate_after got %0b exp 0", fault);
        end
        checks++;
        if (fault_count !== 8'd6) begin
            errors++; $display("FAIL gate_count got %0d exp 6", fault_count);
        end
        for (int i = 0; i < 4; i++) step(Y, R, 1'b0, 1'b0);
        step(R, R, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL gate_yr got %0b exp 0", fault);
        end
    endtask

    task automatic test_hold_saturation;
        step(G, R, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(Y, R, 1'b0, 1'b0);
        step(R, R, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL holdsat_fault got %0b exp 0", fault);
        end
    endtask

    task automatic test_count_saturation;
        reset = 1'b1;
        step(R, R, 1'b0, 1'b0);
        reset = 1'b0;
        checks++;
        if (fault_count !== 8'd0) begin
            errors++; $display("FAIL sat_start got %0d exp 0", fault_count);
        end
        for (int i = 0; i < 255; i++) begin
            step(G, G, 1'b0, 1'b0);
            step(R, R, 1'b0, 1'b1);
        end
        checks++;
        if (fault_count !== 8'd255) begin
            errors++; $display("FAIL sat_255 got %0d exp 255", fault_count);
        end
        step(G, G, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL sat_256_fault got %0b exp 1", fault);
        end
        checks++;
        if (fault_count !== 8'd255) begin
            errors++; $display("FAIL sat_256 got %0d exp 255", fault_count);
        end
        reset = 1'b1;
        step(G, G, 1'b0, 1'b0);
        reset = 1'b0;
        checks++;
        if ({fault, fault_code, fault_road, failsafe_flash, fault_count} !== 15'd0) begin
            errors++;
            $display("FAIL sat_reset got f=%0b c=%0d r=%b fl=%0b n=%0d exp all 0",
                     fault, fault_code, fault_road, failsafe_flash, fault_count);
        end
        step(R, R, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL sat_post got %0b exp 0", fault);
        end
    endtask

    initial begin
        reset             = 1'b1;
        main_light        = R;
        side_light        = R;
        pedestrian_signal = 1'b0;
        clear_fault       = 1'b0;
        test_reset();
        test_legal_cycle();
        test_conflict();
        test_short_yellow();
        test_priority();
        test_clear_gating();
        test_hold_saturation();
        test_count_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Independent safety checker on the consumer side of the intersection light bus. Samples main_light, side_light and pedestrian_signal every cycle and checks encoding, conflicts, phase order and minimum yellow time. On the first violation it latches a fault code and asserts a flashing-red failsafe until software clears it. It sits between the light controller and the lamp drivers/fault logger.

Parameters:
TIMER_W, 16, width of per-road hold counters (saturating)
MIN_YELLOW, 1000, minimum consecutive yellow samples before a Y->R transition
MIN_GREEN, 5000, minimum consecutive green samples before G->Y (used only with optional feature)
FLASH_PERIOD, 500, cycles per half-period of failsafe_flash

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high
main_light  in  3  main road lamp, one-hot {R,Y,G}: RED=100, YELLOW=010, GREEN=001
side_light  in  3  side road lamp, same encoding
pedestrian_signal  in  1  walk lamp
clear_fault  in  1  single-cycle request to leave FAULT
fault  out  1  high while in FAULT
fault_code  out  3  latched cause, 0 = none
fault_road  out  2  bit0 = main, bit1 = side; both set for conflict/ped faults
failsafe_flash  out  1  flashing red enable, toggles in FAULT
fault_count  out  8  number of FAULT entries, saturates at 255

Behaviour:
- One clock; reset synchronous and active-high.
- Reset: prev_main = prev_side = RED; hold counters = 0; state MONITOR; all outputs 0.
- Per-road hold counter:
  - Current sample == prev: increment, saturating at 2^TIMER_W-1.
  - Otherwise: load 1.
  - prev is updated every cycle.
- Checks, evaluated combinationally on current sample vs prev, MONITOR state only. Lowest code wins when several fire in the same cycle:
  - 1 ENCODING: either light not in {100, 010, 001}.
  - 2 CONFLICT: main != RED and side != RED.
  - 3 SEQUENCE: a light changes value but not via G->Y, Y->R or R->G.
  - 4 SHORT_YELLOW: Y->R with that road's hold counter < MIN_YELLOW.
  - 5 PED_UNSAFE: pedestrian_signal = 1 while either light != RED.
- fault_road: for codes 1, 3 and 4, the set of offending roads (both roads may be set). For codes 2 and 5, fault_road = 11.
- State machine:
  - MONITOR: on a violation in cycle t, latch fault_code/fault_road, increment fault_count and go to FAULT. fault is high from cycle t+1 (1-cycle latency).
  - FAULT:
    - Checks are disabled and the latched code is held.
    - failsafe_flash starts at 1 on entry and toggles every FLASH_PERIOD cycles via an internal counter.
    - clear_fault is honoured only when the same-cycle sample has main = side = RED and pedestrian_signal = 0. Otherwise it is ignored, with no queuing.
    - Honoured clear: next cycle returns to MONITOR; fault, fault_code, fault_road and failsafe_flash go to 0; hold counters reload to 1; flash counter clears.
- clear_fault in MONITOR has no effect.
- Reset mid-FAULT: full reset, including fault_count.
- Hold counter saturation must not produce a false SHORT_YELLOW, since the comparison is on the saturated value.
- Hold counters keep running in FAULT, so timing stays valid after a clear.

Optional Feature:
MONITOR_MIN_GREEN_EN
- Defined: adds check code 6 SHORT_GREEN, raised on G->Y with that road's hold counter < MIN_GREEN. It has the lowest priority.
- Undefined: code 6 is never produced, and MIN_GREEN is unused with no logic generated.

Test Plan:
All scenarios use MIN_YELLOW=4, FLASH_PERIOD=2, TIMER_W=8.
1. Legal cycle: main G(10 cycles) -> Y(4) -> R, side R -> G -> Y(4) -> R, repeated 3 times -> fault = 0 throughout, fault_count = 0.
2. Conflict: main = GREEN while side switches to GREEN at cycle t -> fault = 1 at t+1, fault_code = 2, fault_road = 11, fault_count = 1; failsafe_flash = 1,1,0,0,1,1...
3. Short yellow: main Y for 3 cycles then R -> fault_code = 4, fault_road = 01. Y for exactly 4 cycles then R -> no fault.
4. Sequence plus encoding in the same cycle: main G->R directly while side = 110 -> fault_code = 1 (priority), fault_road = 11.
5. Clear gating in FAULT:
   - clear_fault while main = GREEN -> stays in FAULT.
   - clear_fault with both RED and ped = 0 -> fault = 0 the next cycle.
   - A subsequent legal R->G -> no fault.
6. Saturation: 255 conflict faults, each followed by a valid clear -> fault_count = 255 after the 255th and stays 255 after a 256th. Then reset high for 1 cycle -> all outputs 0.
